// File: rtl/feature_fetch.sv
// feature_fetch: reads words from one of two feature banks and streams them out as Tn-feature chunks
module feature_fetch #(
   parameter int Tn             = 4,
   parameter int FEATURE_WIDTH  = 16,
   parameter int DATA_BUS_WIDTH = 128,
   parameter int ADDR_WIDTH     = 8
) (
   input  logic                        clk,
   input  logic                        rst,
   input  logic                        start,
   input  logic                        rd_buf_sel,
   input  logic [ADDR_WIDTH:0]         word_count,
   output logic                        busy,
   output logic                        done,
   output logic                        rd_en_0,
   output logic [ADDR_WIDTH-1:0]       rd_addr_0,
   input  logic [DATA_BUS_WIDTH-1:0]   rd_data_0,
   output logic                        rd_en_1,
   output logic [ADDR_WIDTH-1:0]       rd_addr_1,
   input  logic [DATA_BUS_WIDTH-1:0]   rd_data_1,
   output logic                        out_valid,
   input  logic                        out_ready,
   output logic [Tn*FEATURE_WIDTH-1:0] out_data,
   output logic                        out_last
);
   localparam int TW     = Tn * FEATURE_WIDTH;
   localparam int CHUNKS = DATA_BUS_WIDTH / TW;
   localparam int CW     = (CHUNKS > 1) ? $clog2(CHUNKS) : 1;
   localparam logic [CW-1:0] LAST_C = CW'(CHUNKS - 1);
   localparam logic [CW-1:0] ONE_C = CW'(1);
   localparam logic [ADDR_WIDTH:0] ONE_W = (ADDR_WIDTH + 1)'(1);

   typedef enum logic [2:0] {IDLE, FETCH, WAIT, SHIFT, DONE} state_t;

   state_t                    state_q, state_d;
   logic                      sel_q, sel_d;
   logic [ADDR_WIDTH:0]       count_q, count_d;
   logic [ADDR_WIDTH:0]       word_idx_q, word_idx_d;
   logic [CW-1:0]             chunk_q, chunk_d;
   logic [DATA_BUS_WIDTH-1:0] shift_q, shift_d;
   logic                      last_chunk, last_word;

   assign last_chunk = chunk_q == LAST_C;
   assign last_word  = word_idx_q == count_q - ONE_W;

   // state and datapath registers; reset aborts any transfer at once
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= IDLE;
         sel_q      <= 1'b0;
         count_q    <= '0;
         word_idx_q <= '0;
         chunk_q    <= '0;
         shift_q    <= '0;
      end else begin
         state_q    <= state_d;
         sel_q      <= sel_d;
         count_q    <= count_d;
         word_idx_q <= word_idx_d;
         chunk_q    <= chunk_d;
         shift_q    <= shift_d;
      end
   end

   // next state: one read per word, then drain its chunks low-order first
   always_comb begin
      state_d    = state_q;
      sel_d      = sel_q;
      count_d    = count_q;
      word_idx_d = word_idx_q;
      chunk_d    = chunk_q;
      shift_d    = shift_q;
      case (state_q)
         IDLE: begin
            if (start) begin
               sel_d      = rd_buf_sel;
               count_d    = word_count;
               word_idx_d = '0;
               state_d    = (word_count == '0) ? DONE : FETCH;
            end
         end
         FETCH: state_d = WAIT;
         WAIT: begin
            shift_d = sel_q ? rd_data_1 : rd_data_0;
            chunk_d = '0;
            state_d = SHIFT;
         end
         SHIFT: begin
            if (out_ready) begin
               if (last_chunk) begin
                  word_idx_d = last_word ? word_idx_q : word_idx_q + ONE_W;
                  state_d    = last_word ? DONE : FETCH;
               end else begin
                  shift_d = shift_q >> TW;
                  chunk_d = chunk_q + ONE_C;
               end
            end
         end
         DONE: state_d = IDLE;
         default: state_d = IDLE;
      endcase
   end

   assign busy      = state_q != IDLE;
   assign done      = state_q == DONE;
   assign rd_en_0   = (state_q == FETCH) && !sel_q;
   assign rd_en_1   = (state_q == FETCH) && sel_q;
   assign rd_addr_0 = rd_en_0 ? word_idx_q[ADDR_WIDTH-1:0] : '0;
   assign rd_addr_1 = rd_en_1 ? word_idx_q[ADDR_WIDTH-1:0] : '0;
   assign out_valid = state_q == SHIFT;
   assign out_data  = out_valid ? shift_q[TW-1:0] : '0;
   assign out_last  = out_valid && last_chunk && last_word;
endmodule
